frame_rr_scheduler: RTL and testbench

// Output-port scheduler for the switch packet buffers. Shares one egress port

---
 rtl/frame_rr_scheduler.sv | 140 ++++++++++++++
 tb/tb_frame_rr_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rr_scheduler.sv
// Round-robin frame scheduler: grants one ingress descriptor at a time, issues exactly
// len reads to that ingress FIFO and streams the words to egress through a 2-entry buffer.
module frame_rr_scheduler #(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_LEN_WIDTH  = 11,
  localparam int SRC_W       = $clog2(P_NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [P_NUM_REQ-1:0]              desc_valid_i,
  input  logic [P_NUM_REQ*P_LEN_WIDTH-1:0]  desc_len_i,
  output logic [P_NUM_REQ-1:0]              desc_pop_o,
  input  logic [P_NUM_REQ-1:0]              fifo_empty_i,
  output logic [P_NUM_REQ-1:0]              fifo_rd_o,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] fifo_data_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [P_DATA_WIDTH-1:0]           out_data_o,
  output logic                              out_last_o,
  output logic [SRC_W-1:0]                  out_src_o,
  output logic                              busy_o
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                   state_q, state_d;
  logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]         src_q, src_d;
  logic [P_LEN_WIDTH-1:0]   rem_q, rem_d;
  logic                     inflight_q, infl_last_q;
  logic [SRC_W-1:0]         infl_src_q;
  logic [1:0]               occ_q;
  logic                     wr_ptr_q, rd_ptr_q;
  logic [P_DATA_WIDTH-1:0]  buf_data_q [2];
  logic                     buf_last_q [2];
  logic [SRC_W-1:0]         buf_src_q  [2];

  logic                     grant_found;
  logic [SRC_W-1:0]         grant_idx;
  logic [P_LEN_WIDTH-1:0]   grant_len;
  int                       scan_idx;
  logic                     pop_en, rd_en, out_pop, credit_ok;
  logic [2:0]               credit_cnt;

  // Scan from the farthest offset down so the first requester at/after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_q) + k) % P_NUM_REQ;
      if (desc_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(scan_idx);
      end
    end
  end

  assign grant_len = desc_len_i[grant_idx*P_LEN_WIDTH +: P_LEN_WIDTH];

  assign out_valid_o = !rst_i && (occ_q != 2'd0);
  assign out_pop     = out_valid_o && out_ready_i;
  // Projected occupancy once the word already in flight has landed.
  assign credit_cnt  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, out_pop};
  assign credit_ok   = (credit_cnt < 3'd2);

  assign pop_en = !rst_i && (state_q == IDLE) && grant_found;
  assign rd_en  = !rst_i && (state_q == XFER) && (rem_q != '0) &&
                  !fifo_empty_i[src_q] && credit_ok;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    rem_d    = rem_q;
    case (state_q)
      IDLE: begin
        if (pop_en) begin
          src_d    = grant_idx;
          rem_d    = grant_len;
          rr_ptr_d = (grant_idx == SRC_W'(P_NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          if (grant_len != '0) state_d = XFER;
        end
      end
      XFER: begin
        if (rd_en) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == P_LEN_WIDTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      src_q       <= '0;
      rem_q       <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      infl_src_q  <= '0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      src_q       <= src_d;
      rem_q       <= rem_d;
      inflight_q  <= rd_en;
      infl_last_q <= rd_en && (rem_q == P_LEN_WIDTH'(1));
      infl_src_q  <= src_q;
      occ_q       <= occ_q + {1'b0, inflight_q} - {1'b0, out_pop};
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (out_pop)    rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && inflight_q) begin
      buf_data_q[wr_ptr_q] <= fifo_data_i[infl_src_q*P_DATA_WIDTH +: P_DATA_WIDTH];
      buf_last_q[wr_ptr_q] <= infl_last_q;
      buf_src_q[wr_ptr_q]  <= infl_src_q;
    end
  end

  for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_strobe
    assign desc_pop_o[gi] = pop_en && (grant_idx == SRC_W'(gi));
    assign fifo_rd_o[gi]  = rd_en && (src_q == SRC_W'(gi));
  end

  assign out_data_o = out_valid_o ? buf_data_q[rd_ptr_q] : '0;
  assign out_last_o = out_valid_o ? buf_last_q[rd_ptr_q] : 1'b0;
  assign out_src_o  = out_valid_o ? buf_src_q[rd_ptr_q]  : '0;
  assign busy_o     = !rst_i && ((state_q == XFER) || (occ_q != 2'd0) || inflight_q);

endmodule

// File: tb/tb_frame_rr_scheduler.sv
// Directed bench for frame_rr_scheduler: FIFO/descriptor models, egress scoreboard
// and cycle-exact checks of latency, fairness, backpressure, underrun and edge lengths.
module tb_frame_rr_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int SW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      desc_valid_i;
  logic [N*LW-1:0]   desc_len_i;
  logic [N-1:0]      desc_pop_o;
  logic [N-1:0]      fifo_empty_i;
  logic [N-1:0]      fifo_rd_o;
  logic [N*DW-1:0]   fifo_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DW-1:0]     out_data_o;
  logic              out_last_o;
  logic [SW-1:0]     out_src_o;
  logic              busy_o;

  frame_rr_scheduler #(.P_NUM_REQ(N), .P_DATA_WIDTH(DW), .P_LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .desc_valid_i(desc_valid_i), .desc_len_i(desc_len_i), .desc_pop_o(desc_pop_o),
    .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o), .fifo_data_i(fifo_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .out_src_o(out_src_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int unsigned        desc_q [N][$];
  logic [DW-1:0]      data_q [N][$];
  logic [DW+SW:0]     exp_q  [$];
  int                 grant_log [$];
  int                 rd_cnt [N];
  int                 seq [N];
  logic [N-1:0]       stall;
  logic [N-1:0]       rd_s, pop_s;

  task automatic refresh();
    int unsigned tmp;
    for (int i = 0; i < N; i++) begin
      tmp = (desc_q[i].size() > 0) ? desc_q[i][0] : 0;
      desc_valid_i[i]          = (desc_q[i].size() > 0);
      desc_len_i[i*LW +: LW]   = tmp[LW-1:0];
      fifo_empty_i[i]          = (data_q[i].size() == 0) || stall[i];
    end
  endtask

  task automatic push_frame(input int r, input int len);
    logic [DW-1:0] w;
    desc_q[r].push_back(len);
    for (int n = 0; n < len; n++) begin
      w = DW'((r << 16) | seq[r]);
      seq[r]++;
      data_q[r].push_back(w);
      exp_q.push_back({(n == len - 1), SW'(r), w});
    end
    refresh();
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && !busy_o) break;
      step();
    end
    check(tag, {busy_o, 32'(exp_q.size())}, 0);
  endtask

  // FIFO / descriptor model: strobes sampled at the edge, effects applied just after.
  always begin
    @(posedge clk_i);
    rd_s  = fifo_rd_o;
    pop_s = desc_pop_o;
    #1;
    for (int i = 0; i < N; i++) begin
      if (pop_s[i]) begin
        if (desc_q[i].size() > 0) void'(desc_q[i].pop_front());
        grant_log.push_back(i);
      end
      if (rd_s[i]) begin
        rd_cnt[i]++;
        check("rd_not_empty", 64'(data_q[i].size() > 0), 1);
        if (data_q[i].size() > 0) fifo_data_i[i*DW +: DW] = data_q[i].pop_front();
      end
    end
    refresh();
  end

  // Egress scoreboard and hold-stability monitor.
  logic           hold;
  logic [DW+SW:0] hold_word, word, expw;
  always @(negedge clk_i) begin
    if (rst_i) begin
      hold = 1'b0;
    end else begin
      word = {out_last_o, out_src_o, out_data_o};
      check("rd_onehot", 64'($countones(fifo_rd_o) <= 1), 1);
      if (hold) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_word", word, hold_word);
      end
      if (out_valid_o && out_ready_i) begin
        expw = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        $display("egress src=%0d data=0x%08h last=%0b", out_src_o, out_data_o, out_last_o);
        check("word", word, expw);
      end
      hold      = out_valid_o && !out_ready_i;
      hold_word = word;
    end
  end

  logic [3:0] rd_tab    [8] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
  logic [3:0] pop_tab   [8] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic       valid_tab [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  logic       last_tab  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  logic       busy_tab  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
  int         grant_exp [5] = '{0, 1, 2, 3, 0};
  int         base;

  initial begin
    rst_i = 1'b1; out_ready_i = 1'b1; stall = '0; fifo_data_i = '0; hold = 1'b0;
    for (int i = 0; i < N; i++) begin rd_cnt[i] = 0; seq[i] = 0; end
    refresh();
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("init_outputs", {desc_pop_o, fifo_rd_o, out_valid_o, out_last_o, out_src_o, busy_o}, 0);

    // Single frame, cycle-exact latency
    step();
    push_frame(1, 4);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      $display("cycle t+%0d pop=%b rd=%b valid=%b last=%b busy=%b", c, desc_pop_o, fifo_rd_o,
               out_valid_o, out_last_o, busy_o);
      check($sformatf("single_pop_t%0d", c), desc_pop_o, pop_tab[c]);
      check($sformatf("single_rd_t%0d", c), fifo_rd_o, rd_tab[c]);
      check($sformatf("single_valid_t%0d", c), out_valid_o, valid_tab[c]);
      check($sformatf("single_last_t%0d", c), out_last_o, last_tab[c]);
      check($sformatf("single_busy_t%0d", c), busy_o, busy_tab[c]);
      if (valid_tab[c]) check("single_src", out_src_o, 1);
      step();
    end
    drain("single_drain");

    // Reset mid-frame
    push_frame(2, 8);
    repeat (4) step();
    rst_i = 1'b1;
    for (int i = 0; i < N; i++) begin desc_q[i].delete(); data_q[i].delete(); end
    exp_q.delete();
    refresh();
    repeat (3) step();
    @(negedge clk_i);
    check("rst_outputs", {desc_pop_o, fifo_rd_o, out_valid_o, out_last_o, out_src_o, busy_o}, 0);
    check("rst_data", out_data_o, 0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_outputs", {desc_pop_o, fifo_rd_o, out_valid_o, out_last_o, out_src_o, busy_o}, 0);
    step();

    // Fairness: rr_ptr back at 0, req0 rerequests
    grant_log.delete();
    push_frame(0, 2); push_frame(1, 2); push_frame(2, 2); push_frame(3, 2); push_frame(0, 2);
    drain("fair_drain");
    check("fair_grants", grant_log.size(), 5);
    for (int g = 0; g < 5; g++)
      check($sformatf("fair_grant%0d", g), (g < grant_log.size()) ? grant_log[g] : -1, grant_exp[g]);

    // Backpressure: ready toggling
    push_frame(3, 8);
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && !busy_o) break;
      out_ready_i = ~out_ready_i;
      step();
    end
    out_ready_i = 1'b1;
    drain("bp_drain");

    // Underrun: FIFO empty for 5 cycles after the second read
    base = rd_cnt[2];
    push_frame(2, 6);
    for (int c = 0; c < 50; c++) begin
      if (rd_cnt[2] >= base + 2) break;
      step();
    end
    check("under_reads_before_stall", rd_cnt[2] - base, 2);
    stall[2] = 1'b1;
    refresh();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("under_rd_c%0d", c), fifo_rd_o, 0);
      step();
    end
    stall[2] = 1'b0;
    refresh();
    drain("under_drain");
    check("under_total_reads", rd_cnt[2] - base, 6);

    // Zero-length descriptor, then single-word frame
    push_frame(0, 0);
    @(negedge clk_i);
    check("len0_pop", desc_pop_o, 4'h1);
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check($sformatf("len0_idle_c%0d", c), {fifo_rd_o, out_valid_o, busy_o}, 0);
      step();
    end
    check("len0_desc_gone", desc_q[0].size(), 0);
    base = rd_cnt[1];
    push_frame(1, 1);
    drain("len1_drain");
    check("len1_reads", rd_cnt[1] - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
